// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
package lsu_pkg;

  // Transaction FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Access width of the latched op
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } lsu_size_e;

  // Completion fault causes
  localparam logic [1:0] FAULT_NONE        = 2'd0;
  localparam logic [1:0] FAULT_LD_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_ST_MISALIGN = 2'd2;
  localparam logic [1:0] FAULT_TIMEOUT     = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering shared by the store path (strobe, replicated data)
// and the load path (lane select plus sign/zero extension).
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_rs2_val,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_lane;

  // Move the addressed byte/half down to bit 0
  assign w_lane = i_mem_rdata >> {i_addr_lo, 3'b000};

  // Strobe, write data and extended read data for the access size
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    o_wstrb = 4'b1111;
    o_wdata = i_rs2_val;
    o_rdata = w_lane;
    case (i_size)
      BYTE: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_rs2_val[7:0]}};
        o_rdata = {{24{i_signed & w_lane[7]}}, w_lane[7:0]};
      end
      HALF: begin
        o_wstrb = 4'b0011 << i_addr_lo;
        o_wdata = {2{i_rs2_val[15:0]}};
        o_rdata = {{16{i_signed & w_lane[15]}}, w_lane[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op from the ALU, runs a single data-memory
// transaction over a valid/ready bus and returns the extended load result
// or a fault (misalignment or bus timeout).
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] addr,
  input  logic [31:0] rs2_val,
  input  logic        is_lb,
  input  logic        is_lh,
  input  logic        is_lw,
  input  logic        is_lbu,
  input  logic        is_lhu,
  input  logic        is_sb,
  input  logic        is_sh,
  input  logic        is_sw,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] rd_val,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr
);

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

  lsu_state_e  r_state, w_next;
  lsu_size_e   r_size, w_dec_size, w_al_size;
  logic        r_signed, r_store;
  logic [31:0] r_addr;
  logic [15:0] r_cnt;
  logic [31:0] r_mem_addr, r_mem_wdata, r_rd_val, r_fault_addr;
  logic [3:0]  r_mem_wstrb;
  logic        r_mem_we, r_fault;
  logic [1:0]  r_fault_cause;

  logic        w_dec_any, w_dec_store, w_dec_signed, w_misalign;
  logic [1:0]  w_al_lo;
  logic [3:0]  w_al_wstrb;
  logic [31:0] w_al_wdata, w_al_rdata;

  // One-hot op decode; illegal multi-hot resolves by fixed priority
  always_comb begin
    w_dec_any    = 1'b1;
    w_dec_store  = 1'b0;
    w_dec_signed = 1'b0;
    w_dec_size   = WORD;
    if (is_lw) begin
      w_dec_size = WORD;
    end else if (is_lh) begin
      w_dec_size   = HALF;
      w_dec_signed = 1'b1;
    end else if (is_lhu) begin
      w_dec_size = HALF;
    end else if (is_lb) begin
      w_dec_size   = BYTE;
      w_dec_signed = 1'b1;
    end else if (is_lbu) begin
      w_dec_size = BYTE;
    end else if (is_sw) begin
      w_dec_size  = WORD;
      w_dec_store = 1'b1;
    end else if (is_sh) begin
      w_dec_size  = HALF;
      w_dec_store = 1'b1;
    end else if (is_sb) begin
      w_dec_size  = BYTE;
      w_dec_store = 1'b1;
    end else begin
      w_dec_any = 1'b0;
    end
  end

  assign w_misalign = w_dec_any &&
                      (((w_dec_size == HALF) && addr[0]) ||
                       ((w_dec_size == WORD) && (addr[1:0] != 2'b00)));

  // In IDLE the aligner builds the store request from the incoming op;
  // afterwards it steers the load response using the latched op.
  assign w_al_size = (r_state == IDLE) ? w_dec_size : r_size;
  assign w_al_lo   = (r_state == IDLE) ? addr[1:0]  : r_addr[1:0];

  lsu_align u_align (
    .i_size      (w_al_size),
    .i_addr_lo   (w_al_lo),
    .i_signed    (r_signed),
    .i_rs2_val   (rs2_val),
    .i_mem_rdata (mem_rdata),
    .o_wstrb     (w_al_wstrb),
    .o_wdata     (w_al_wdata),
    .o_rdata     (w_al_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = (!w_dec_any || w_misalign) ? DONE : REQ;
      REQ:     if (mem_req_ready) w_next = WAIT;
      WAIT:    if (mem_rsp_valid || (r_cnt == LP_TIMEOUT)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand latches, request registers, timeout counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr        <= '0;
      r_size        <= BYTE;
      r_signed      <= 1'b0;
      r_store       <= 1'b0;
      r_cnt         <= '0;
      r_mem_addr    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_wstrb   <= '0;
      r_mem_wdata   <= '0;
      r_rd_val      <= '0;
      r_fault       <= 1'b0;
      r_fault_cause <= FAULT_NONE;
      r_fault_addr  <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_addr   <= addr;
          r_size   <= w_dec_size;
          r_signed <= w_dec_signed;
          r_store  <= w_dec_store;
          if (!w_dec_any) begin
            r_rd_val      <= '0;
            r_fault       <= 1'b0;
            r_fault_cause <= FAULT_NONE;
            r_fault_addr  <= '0;
          end else if (w_misalign) begin
            r_rd_val      <= '0;
            r_fault       <= 1'b1;
            r_fault_cause <= w_dec_store ? FAULT_ST_MISALIGN : FAULT_LD_MISALIGN;
            r_fault_addr  <= addr;
          end else begin
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_we    <= w_dec_store;
            r_mem_wstrb <= w_dec_store ? w_al_wstrb : 4'b0000;
            r_mem_wdata <= w_dec_store ? w_al_wdata : 32'd0;
          end
        end
        REQ: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (mem_rsp_valid) begin
            r_rd_val      <= r_store ? 32'd0 : w_al_rdata;
            r_fault       <= 1'b0;
            r_fault_cause <= FAULT_NONE;
            r_fault_addr  <= '0;
          end else if (r_cnt == LP_TIMEOUT) begin
            r_rd_val      <= '0;
            r_fault       <= 1'b1;
            r_fault_cause <= FAULT_TIMEOUT;
            r_fault_addr  <= r_addr;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready      = (r_state == IDLE);
  assign mem_req_valid = (r_state == REQ);
  assign out_valid     = (r_state == DONE);
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_wstrb     = r_mem_wstrb;
  assign mem_wdata     = r_mem_wdata;
  assign rd_val        = r_rd_val;
  assign fault         = r_fault;
  assign fault_cause   = r_fault_cause;
  assign fault_addr    = r_fault_addr;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stimulus predicts requests and completions from
// the ISA load/store rules; a negedge monitor compares what the DUT presents.
module tb_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] addr, rs2_val;
  logic        is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        out_valid, fault;
  logic [31:0] rd_val, fault_addr;
  logic [1:0]  fault_cause;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .rs2_val(rs2_val),
    .is_lb(is_lb), .is_lh(is_lh), .is_lw(is_lw), .is_lbu(is_lbu),
    .is_lhu(is_lhu), .is_sb(is_sb), .is_sh(is_sh), .is_sw(is_sw),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .rd_val(rd_val), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] rd; logic flt; logic [1:0] cause; logic [31:0] fa;
  } cpl_t;
  typedef struct packed {
    logic [31:0] a; logic we; logic [3:0] strb; logic [31:0] wd;
  } req_t;

  cpl_t cpl_q[$];
  req_t req_q[$];
  cpl_t mon_c;
  int checks = 0, errors = 0, done_cnt = 0, last_done = 0;
  logic [31:0] mem [logic [31:0]];
  int cfg_rdy_d = 0, cfg_rsp_d = 0;
  bit cfg_rsp_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory contents: explicit entries, else a fixed address hash
  function automatic logic [31:0] mem_val(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return {wa[15:0], ~wa[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model. op: 0 lb 1 lh 2 lw 3 lbu 4 lhu 5 sb 6 sh 7 sw 8 none
  task automatic predict(input int op, input logic [31:0] a, input logic [31:0] rs2,
                         input bit rsp_en, input int rsp_d);
    int sz, off;
    bit st, sgn;
    logic [63:0] mask, v;
    cpl_t c;
    req_t r;
    off = int'(a[1:0]);
    st  = (op >= 5 && op <= 7);
    sgn = (op == 0 || op == 1);
    sz  = (op == 0 || op == 3 || op == 5) ? 1 : (op == 1 || op == 4 || op == 6) ? 2 : 4;
    c = '0;
    r = '0;
    if (op == 8) begin
      c = '0;
    end else if (off % sz != 0) begin
      c.flt = 1'b1; c.cause = st ? 2'd2 : 2'd1; c.fa = a;
    end else begin
      mask   = (64'd1 << (8 * sz)) - 64'd1;
      r.a    = a & 32'hFFFF_FFFC;
      r.we   = st;
      r.strb = st ? 4'(((1 << sz) - 1) << off) : 4'd0;
      r.wd   = (sz == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
               (sz == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      req_q.push_back(r);
      if (!rsp_en || rsp_d > TO) begin
        c.flt = 1'b1; c.cause = 2'd3; c.fa = a;
      end else if (!st) begin
        v = (64'(mem_val(r.a)) >> (8 * off)) & mask;
        if (sgn && v[8 * sz - 1]) v = v | ~mask;
        c.rd = v[31:0];
      end
    end
    cpl_q.push_back(c);
  endtask

  // Memory responder: ready after cfg_rdy_d cycles, response cfg_rsp_d cycles later
  initial begin : responder
    int rd_d, sp_d;
    bit en;
    logic [31:0] wa;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_valid && !rst) begin
        rd_d = cfg_rdy_d; en = cfg_rsp_en; sp_d = cfg_rsp_d;
        repeat (rd_d) begin @(posedge clk); #1; end
        wa = mem_addr;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (en) begin
          repeat (sp_d) begin @(posedge clk); #1; end
          mem_rdata = mem_val(wa);
          mem_rsp_valid = 1'b1;
          @(posedge clk); #1;
          mem_rsp_valid = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: compares presented requests and completions with the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid) begin
        if (req_q.size() == 0) flag_fail("unexpected_request");
        else begin
          check("req_addr", mem_addr, req_q[0].a);
          check("req_we", 32'(mem_we), 32'(req_q[0].we));
          check("req_wstrb", 32'(mem_wstrb), 32'(req_q[0].strb));
          if (req_q[0].we) check("req_wdata", mem_wdata, req_q[0].wd);
          if (mem_req_ready) void'(req_q.pop_front());
        end
      end
      if (out_valid) begin
        done_cnt++;
        last_done = cyc;
        if (cpl_q.size() == 0) flag_fail("unexpected_completion");
        else begin
          mon_c = cpl_q.pop_front();
          check("rd_val", rd_val, mon_c.rd);
          check("fault", 32'(fault), 32'(mon_c.flt));
          check("fault_cause", 32'(fault_cause), 32'(mon_c.cause));
          check("fault_addr", fault_addr, mon_c.fa);
        end
      end
    end
  end

  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] rs2,
                       input int rdy_d, input bit rsp_en, input int rsp_d,
                       input bit hold, output int acc);
    int n;
    n = 0;
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = 8'b0;
    case (op)
      0: is_lb = 1'b1;   1: is_lh = 1'b1;   2: is_lw = 1'b1;
      3: is_lbu = 1'b1;  4: is_lhu = 1'b1;  5: is_sb = 1'b1;
      6: is_sh = 1'b1;   7: is_sw = 1'b1;
      default: ;
    endcase
    addr = a; rs2_val = rs2; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) flag_fail("accept_timeout");
    cfg_rdy_d = rdy_d; cfg_rsp_en = rsp_en; cfg_rsp_d = rsp_d;
    predict(op, a, rs2, rsp_en, rsp_d);
    acc = cyc;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (cpl_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (cpl_q.size() != 0) flag_fail("completion_timeout");
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rd_val"}, rd_val, 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_cause"}, 32'(fault_cause), 32'd0);
    check({tag, "_fault_addr"}, fault_addr, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, acc2, d0, op;
    bit en;
    rst = 1'b1; in_valid = 1'b0; addr = '0; rs2_val = '0;
    {is_lb, is_lh, is_lw, is_lbu, is_lhu, is_sb, is_sh, is_sw} = 8'b0;
    mem[32'h1000] = 32'h80FF_1234;
    mem[32'h4000] = 32'h0000_007F;
    mem[32'h6000] = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_vals("por");

    // lb at byte 3, immediate ready/response: sign-extended 0x80, 3-cycle latency
    issue(0, 32'h1003, 32'h0, 0, 1'b1, 0, 1'b0, acc);
    wait_done();
    check("lb_latency", 32'(last_done - acc), 32'd3);

    // sh at upper half with ready held off 4 cycles
    issue(6, 32'h2002, 32'hDEAD_BEEF, 4, 1'b1, 0, 1'b0, acc);
    wait_done();
    check("sh_latency", 32'(last_done - acc), 32'd7);

    // misaligned lw / sw: no request, completion in cycle 1
    issue(2, 32'h3001, 32'h0, 0, 1'b1, 0, 1'b0, acc);
    wait_done();
    check("lw_misalign_latency", 32'(last_done - acc), 32'd1);
    issue(7, 32'h3002, 32'h1111_2222, 0, 1'b1, 0, 1'b0, acc);
    wait_done();
    check("sw_misalign_latency", 32'(last_done - acc), 32'd1);

    // lhu timeout; the response arrives 2 cycles after the fault completion
    d0 = done_cnt;
    issue(4, 32'h5002, 32'h0, 0, 1'b1, TO + 3, 1'b0, acc);
    wait_done();
    check("timeout_latency", 32'(last_done - acc), 32'(TO + 3));
    repeat (4) begin @(posedge clk); #1; end
    check("timeout_single_pulse", 32'(done_cnt), 32'(d0 + 1));

    // reset while in WAIT, response arrives the following cycle
    issue(2, 32'h5000, 32'h0, 0, 1'b1, 1, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    cpl_q.delete();
    req_q.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_vals("mid_reset");
    repeat (4) begin @(posedge clk); #1; end
    check("no_cpl_after_reset", 32'(done_cnt), 32'(d0));
    issue(3, 32'h4000, 32'h0, 0, 1'b1, 0, 1'b0, acc);
    wait_done();

    // back-to-back sb then lw with in_valid held high
    d0 = done_cnt;
    issue(5, 32'h6001, 32'h0000_00AB, 0, 1'b1, 0, 1'b1, acc);
    issue(2, 32'h6000, 32'h0, 0, 1'b1, 0, 1'b0, acc2);
    check("b2b_accept_cycle", 32'(acc2), 32'(last_done + 1));
    wait_done();
    check("b2b_pulses", 32'(done_cnt), 32'(d0 + 2));

    // randomized ops, delays, timeouts and held in_valid
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 8));
      en = ($urandom_range(0, 7) != 0);
      issue(op, $urandom, $urandom, int'($urandom_range(0, 3)), en,
            int'($urandom_range(0, 6)), (i != 299) && ($urandom_range(0, 1) == 1), acc);
    end
    in_valid = 1'b0;
    wait_done();
    repeat (10) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
